// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: sequencing controller that turns a bank of N T flip-flops
// into a programmable modulo-M counter with start/stop, enable, one-shot mode
// and a terminal-count pulse. The bank holds the count; this block only
// computes the per-bit toggles from the fed-back q values.
// Optional feature macro: TFF_CTRL_DOWN_EN (adds down counting via dir_i).
module tff_count_ctrl #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         en_i,
  input  logic         oneshot_i,
  input  logic         dir_i,
  input  logic [N-1:0] mod_val_i,
  input  logic [N-1:0] q_fb_i,
  output logic [N-1:0] t_out_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         tc_o
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q;
  logic [N-1:0] m_q;
  logic         os_q;
  logic         busy_q;
  logic         done_q;
  logic         tc_q;

  logic [N-1:0] cnt_d;
  logic [N-1:0] m_last;
  logic         in_rng;
  logic         wrap;
  logic         step;

`ifdef TFF_CTRL_DOWN_EN
  logic         dir_q;
`else
  logic         unused_dir;
  assign unused_dir = dir_i;
`endif

  // M=0 encodes 2^N: M-1 then wraps to all ones and every q is in range.
  assign m_last = m_q - ONE;
  assign in_rng = (m_q == '0) || (q_fb_i < m_q);
  assign step   = (state_q == RUN) && !stop_i && en_i;

  // Next count value the bank must hold, plus wrap detection.
  // Out-of-range counts are forced back to 0 without flagging a wrap.
  always_comb begin
    cnt_d = '0;
    wrap  = 1'b0;
    if (in_rng) begin
`ifdef TFF_CTRL_DOWN_EN
      if (dir_q) begin
        if (q_fb_i == '0) begin
          cnt_d = m_last;
          wrap  = 1'b1;
        end else begin
          cnt_d = q_fb_i - ONE;
        end
      end else begin
        if (q_fb_i == m_last) wrap  = 1'b1;
        else                  cnt_d = q_fb_i + ONE;
      end
`else
      if (q_fb_i == m_last) wrap  = 1'b1;
      else                  cnt_d = q_fb_i + ONE;
`endif
    end
  end

  // Toggle mask: flip exactly the bits that differ from the target value.
  always_comb begin
    t_out_o = '0;
    if (state_q == CLEAR) t_out_o = q_fb_i;
    else if (step)        t_out_o = q_fb_i ^ cnt_d;
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      m_q     <= '0;
      os_q    <= 1'b0;
`ifdef TFF_CTRL_DOWN_EN
      dir_q   <= 1'b0;
`endif
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q <= CLEAR;
            m_q     <= mod_val_i;
            os_q    <= oneshot_i;
`ifdef TFF_CTRL_DOWN_EN
            dir_q   <= dir_i;
`endif
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        CLEAR: state_q <= RUN;
        RUN: begin
          if (stop_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (en_i && wrap) begin
            tc_q <= 1'b1;
            if (os_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign tc_o   = tc_q;

endmodule
